// File: rtl/axi_mmio_csr_responder_if.sv
// AXI4 MMIO channel bundle (AW/W/B/AR/R) between a master and the CSR responder.
// The master modport drives requests; the slave modport drives responses.
interface axi_mmio_csr_responder_if #(
  parameter int unsigned ID_WIDTH   = 9,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                  s_awvalid;
  logic                  s_awready;
  logic [ID_WIDTH-1:0]   s_awid;
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic [7:0]            s_awlen;
  logic [2:0]            s_awsize;

  logic                  s_wvalid;
  logic                  s_wready;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [STRB_W-1:0]     s_wstrb;
  logic                  s_wlast;

  logic                  s_bvalid;
  logic                  s_bready;
  logic [ID_WIDTH-1:0]   s_bid;
  logic [1:0]            s_bresp;

  logic                  s_arvalid;
  logic                  s_arready;
  logic [ID_WIDTH-1:0]   s_arid;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [7:0]            s_arlen;
  logic [2:0]            s_arsize;

  logic                  s_rvalid;
  logic                  s_rready;
  logic [ID_WIDTH-1:0]   s_rid;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rlast;

  modport master (
    output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize,
    input  s_awready,
    output s_wvalid, s_wdata, s_wstrb, s_wlast,
    input  s_wready,
    input  s_bvalid, s_bid, s_bresp,
    output s_bready,
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize,
    input  s_arready,
    input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    output s_rready
  );

  modport slave (
    input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize,
    output s_awready,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast,
    output s_wready,
    output s_bvalid, s_bid, s_bresp,
    input  s_bready,
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize,
    output s_arready,
    output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    input  s_rready
  );
endinterface

// File: rtl/axi_mmio_csr_responder.sv
// AXI4 MMIO responder terminating INCR bursts into a bank of NUM_REGS CSR words,
// with independent write (AW/W/B) and read (AR/R) engines.
// Optional macro AXI_MMIO_CSR_RESPONDER_SIZE_CHECK_EN: reject beats whose size is
// not the full bus width or whose start address is unaligned (SLVERR, no CSR effect).
module axi_mmio_csr_responder #(
  parameter int unsigned ID_WIDTH   = 9,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_mmio_csr_responder_if.slave s
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned REG_AW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  w_state_e              w_state_q;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_idx_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic                  w_dec_q, w_prot_q, w_size_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;

  r_state_e              r_state_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] r_idx_q;
  logic [7:0]            r_len_q, r_cnt_q;
  logic                  r_size_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_size_bad_c, ar_size_bad_c;
  logic                  w_in_range_c, w_last_beat_c;
  logic                  w_dec_d, w_prot_d;
  logic [DATA_WIDTH-1:0] w_merge_c;
  logic [ADDR_WIDTH-1:0] ar_idx_c, r_beat_idx_c;
  logic                  r_beat_bad_c, r_beat_ok_c;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [1:0]            rresp_d;
  logic                  unused_c;

`ifdef AXI_MMIO_CSR_RESPONDER_SIZE_CHECK_EN
  assign aw_size_bad_c = (s.s_awsize != 3'(OFFS)) || (s.s_awaddr[OFFS-1:0] != '0);
  assign ar_size_bad_c = (s.s_arsize != 3'(OFFS)) || (s.s_araddr[OFFS-1:0] != '0);
`else
  assign aw_size_bad_c = 1'b0;
  assign ar_size_bad_c = 1'b0;
`endif
  assign unused_c = ^{s.s_awsize, s.s_arsize};

  assign w_in_range_c  = w_idx_q < ADDR_WIDTH'(NUM_REGS);
  assign w_last_beat_c = (w_cnt_q == w_len_q);
  assign w_dec_d       = w_dec_q | ~w_in_range_c;
  assign w_prot_d      = w_prot_q | (s.s_wlast != w_last_beat_c);

  // Byte-merge the incoming beat over the current word contents.
  always_comb begin
    w_merge_c = mem_q[w_idx_q[REG_AW-1:0]];
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (s.s_wstrb[b]) w_merge_c[8*b +: 8] = s.s_wdata[8*b +: 8];
    end
  end

  // Write engine: accept AW, absorb all W beats, answer on B.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      mem_q     <= '{default: '0};
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_dec_q   <= 1'b0;
      w_prot_q  <= 1'b0;
      w_size_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && s.s_awvalid) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_id_q    <= s.s_awid;
            w_idx_q   <= s.s_awaddr >> OFFS;
            w_len_q   <= s.s_awlen;
            w_cnt_q   <= '0;
            w_dec_q   <= 1'b0;
            w_prot_q  <= 1'b0;
            w_size_q  <= aw_size_bad_c;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wready_q && s.s_wvalid) begin
            if (w_in_range_c && !w_size_q) mem_q[w_idx_q[REG_AW-1:0]] <= w_merge_c;
            w_dec_q  <= w_dec_d;
            w_prot_q <= w_prot_d;
            if (w_last_beat_c) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= w_size_q ? 2'b10 : (w_dec_d ? 2'b11 : (w_prot_d ? 2'b10 : 2'b00));
              w_state_q <= W_RESP;
            end else begin
              w_cnt_q <= w_cnt_q + 8'd1;
              w_idx_q <= w_idx_q + ADDR_WIDTH'(1);
            end
          end
        end
        W_RESP: begin
          if (s.s_bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Address/data of the beat the read engine loads next (first beat when idle).
  assign ar_idx_c     = s.s_araddr >> OFFS;
  assign r_beat_idx_c = (r_state_q == R_IDLE) ? ar_idx_c : (r_idx_q + ADDR_WIDTH'(1));
  assign r_beat_bad_c = (r_state_q == R_IDLE) ? ar_size_bad_c : r_size_q;
  assign r_beat_ok_c  = r_beat_idx_c < ADDR_WIDTH'(NUM_REGS);
  assign rdata_d      = (!r_beat_bad_c && r_beat_ok_c) ? mem_q[r_beat_idx_c[REG_AW-1:0]] : '0;
  assign rresp_d      = r_beat_bad_c ? 2'b10 : (r_beat_ok_c ? 2'b00 : 2'b11);

  // Read engine: accept AR, stream beats on R until the rlast handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s.s_arvalid) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= s.s_arid;
            r_idx_q   <= ar_idx_c;
            r_len_q   <= s.s_arlen;
            r_cnt_q   <= '0;
            r_size_q  <= ar_size_bad_c;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= (s.s_arlen == 8'd0);
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s.s_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rdata_q   <= '0;
              rresp_q   <= '0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_idx_q <= r_beat_idx_c;
              r_cnt_q <= r_cnt_q + 8'd1;
              rdata_q <= rdata_d;
              rresp_q <= rresp_d;
              rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s.s_awready = awready_q;
  assign s.s_wready  = wready_q;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bid     = w_id_q;
  assign s.s_bresp   = bresp_q;
  assign s.s_arready = arready_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rid     = rid_q;
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;
  assign s.s_rlast   = rlast_q;
endmodule

// File: tb/tb_axi_mmio_csr_responder.sv
// Directed + randomized bench for axi_mmio_csr_responder against a CSR-array model.
module tb_axi_mmio_csr_responder;
  localparam int unsigned NREG = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mmio_csr_responder_if #(.ID_WIDTH(9), .ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  axi_mmio_csr_responder #(
    .ID_WIDTH(9), .ADDR_WIDTH(32), .DATA_WIDTH(64), .NUM_REGS(NREG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] ref_mem [NREG];
  logic [63:0] wd_a [256];
  logic [7:0]  ws_a [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit size_bad(input logic [31:0] addr, input logic [2:0] size);
    bit bad = 1'b0;
`ifdef AXI_MMIO_CSR_RESPONDER_SIZE_CHECK_EN
    bad = (size != 3'd3) || (addr[2:0] != 3'd0);
`else
    bad = (size == 3'd7) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    return bad;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input int wlast_beat, input int bstall, input logic [8:0] id);
    int n;
    int unsigned idx;
    bit sb, dec, prot;
    logic [1:0] exp;
    sb   = size_bad(addr, size);
    dec  = 1'b0;
    prot = (wlast_beat != len);
    for (int i = 0; i <= len; i++) begin
      idx = 32'(addr >> 3) + 32'(i);
      if (idx >= NREG) dec = 1'b1;
      else if (!sb)
        for (int b = 0; b < 8; b++)
          if (ws_a[i][b]) ref_mem[4'(idx)][8*b +: 8] = wd_a[i][8*b +: 8];
    end
    exp = sb ? 2'b10 : (dec ? 2'b11 : (prot ? 2'b10 : 2'b00));

    @(negedge clk);
    bus.s_awvalid = 1'b1;
    bus.s_awid    = id;
    bus.s_awaddr  = addr;
    bus.s_awlen   = 8'(len);
    bus.s_awsize  = size;
    n = 0;
    while (!bus.s_awready && n < 100) begin @(negedge clk); n++; end
    check("aw_wait", 64'(n < 100), 64'(1));
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    check("w_ready_latency", 64'(bus.s_wready), 64'(1));
    for (int i = 0; i <= len; i++) begin
      bus.s_wvalid = 1'b1;
      bus.s_wdata  = wd_a[i];
      bus.s_wstrb  = ws_a[i];
      bus.s_wlast  = (i == wlast_beat);
      n = 0;
      while (!bus.s_wready && n < 100) begin @(negedge clk); n++; end
      check("w_wait", 64'(n < 100), 64'(1));
      @(negedge clk);
    end
    bus.s_wvalid = 1'b0;
    bus.s_wlast  = 1'b0;
    check("b_latency", 64'(bus.s_bvalid), 64'(1));
    bus.s_bready = 1'b0;
    for (int k = 0; k < bstall; k++) begin
      check("b_hold_valid", 64'(bus.s_bvalid), 64'(1));
      check("b_hold_resp", 64'(bus.s_bresp), 64'(exp));
      @(negedge clk);
    end
    bus.s_bready = 1'b1;
    n = 0;
    while (!bus.s_bvalid && n < 100) begin @(negedge clk); n++; end
    check("bresp", 64'(bus.s_bresp), 64'(exp));
    check("bid", 64'(bus.s_bid), 64'(id));
    @(negedge clk);
    bus.s_bready = 1'b0;
    check("b_single", 64'(bus.s_bvalid), 64'(0));
    check("aw_reready", 64'(bus.s_awready), 64'(1));
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input int rstall, input logic [8:0] id);
    int n, hold;
    int unsigned idx;
    bit sb;
    logic [63:0] ed;
    logic [1:0] er;
    sb = size_bad(addr, size);
    @(negedge clk);
    bus.s_arvalid = 1'b1;
    bus.s_arid    = id;
    bus.s_araddr  = addr;
    bus.s_arlen   = 8'(len);
    bus.s_arsize  = size;
    n = 0;
    while (!bus.s_arready && n < 100) begin @(negedge clk); n++; end
    check("ar_wait", 64'(n < 100), 64'(1));
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    check("r_latency", 64'(bus.s_rvalid), 64'(1));
    hold = rstall;
    for (int i = 0; i <= len; i++) begin
      idx = 32'(addr >> 3) + 32'(i);
      if (sb) begin ed = '0; er = 2'b10; end
      else if (idx < NREG) begin ed = ref_mem[4'(idx)]; er = 2'b00; end
      else begin ed = '0; er = 2'b11; end
      n = 0;
      do begin
        check("rvalid", 64'(bus.s_rvalid), 64'(1));
        check("rdata", bus.s_rdata, ed);
        check("rresp", 64'(bus.s_rresp), 64'(er));
        check("rlast", 64'(bus.s_rlast), 64'(i == len));
        check("rid", 64'(bus.s_rid), 64'(id));
        if (hold > 0) begin bus.s_rready = 1'b0; hold--; end
        else bus.s_rready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        n++;
      end while (!bus.s_rready && n < 100);
    end
    bus.s_rready = 1'b0;
    check("r_end", 64'(bus.s_rvalid), 64'(0));
    check("ar_reready", 64'(bus.s_arready), 64'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int l, wb;
    rst = 1'b1;
    bus.s_awvalid = 0; bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0;
    bus.s_wvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 0; bus.s_bready = 0;
    bus.s_arvalid = 0; bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0;
    bus.s_rready = 0;
    for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(bus.s_awready), 64'(0));
    check("rst_arready", 64'(bus.s_arready), 64'(0));
    check("rst_wready", 64'(bus.s_wready), 64'(0));
    check("rst_bvalid", 64'(bus.s_bvalid), 64'(0));
    check("rst_rvalid", 64'(bus.s_rvalid), 64'(0));
    check("rst_rdata", bus.s_rdata, 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 64'(bus.s_awready), 64'(1));
    check("post_rst_arready", 64'(bus.s_arready), 64'(1));

    // Single-beat write and read-back.
    wd_a[0] = 64'h0000_0000_DEAD_BEEF; ws_a[0] = 8'hFF;
    axi_write(32'h08, 0, 3'd3, 0, 0, 9'h1A5);
    axi_read(32'h08, 0, 3'd3, 0, 9'h033);

    // Four-beat burst with a partial strobe over a pre-filled word.
    wd_a[0] = 64'hAAAA_BBBB_CCCC_DDDD; ws_a[0] = 8'hFF;
    axi_write(32'h20, 0, 3'd3, 0, 0, 9'h002);
    for (int i = 0; i < 4; i++) begin wd_a[i] = 64'(i + 1); ws_a[i] = 8'hFF; end
    ws_a[2] = 8'h0F;
    axi_write(32'h10, 3, 3'd3, 3, 0, 9'h0F0);
    axi_read(32'h10, 3, 3'd3, 0, 9'h111);

    // Burst running off the end of the bank.
    wd_a[0] = 64'h1515_1515_F00D_CAFE; ws_a[0] = 8'hFF;
    axi_write(32'h78, 0, 3'd3, 0, 0, 9'h015);
    axi_read(32'h78, 1, 3'd3, 0, 9'h0AB);
    wd_a[0] = 64'h5; wd_a[1] = 64'h6; ws_a[0] = 8'hFF; ws_a[1] = 8'hFF;
    axi_write(32'h78, 1, 3'd3, 1, 0, 9'h016);

    // Early wlast: protocol error but both beats still land.
    wd_a[0] = 64'h6666_0000_0000_0006; wd_a[1] = 64'h7777_0000_0000_0007;
    ws_a[0] = 8'hFF; ws_a[1] = 8'hFF;
    axi_write(32'h30, 1, 3'd3, 0, 0, 9'h1FF);
    axi_read(32'h30, 1, 3'd3, 0, 9'h100);

    // Back-pressure on B and R.
    wd_a[0] = 64'h0123_4567_89AB_CDEF; ws_a[0] = 8'hFF;
    axi_write(32'h40, 0, 3'd3, 0, 5, 9'h044);
    axi_read(32'h40, 0, 3'd3, 5, 9'h045);

    // Narrow size / unaligned address handling.
    wd_a[0] = 64'hFEED_FACE_0000_1111; ws_a[0] = 8'hFF;
    axi_write(32'h48, 0, 3'd2, 0, 0, 9'h046);
    axi_read(32'h48, 0, 3'd3, 0, 9'h047);
    wd_a[0] = 64'h2222_3333_4444_5555; ws_a[0] = 8'hF0;
    axi_write(32'h4D, 0, 3'd3, 0, 0, 9'h048);
    axi_read(32'h4B, 1, 3'd3, 0, 9'h049);
    axi_read(32'h48, 0, 3'd2, 0, 9'h04A);

    // Concurrent write and read on disjoint words.
    for (int i = 0; i < 4; i++) begin wd_a[i] = {$urandom, $urandom}; ws_a[i] = 8'($urandom); end
    fork
      axi_write(32'h00, 3, 3'd3, 3, 1, 9'h0C1);
      axi_read(32'h40, 3, 3'd3, 0, 9'h0C2);
    join
    axi_read(32'h00, 3, 3'd3, 0, 9'h0C3);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      a  = 32'($urandom_range(0, 19)) << 3;
      l  = $urandom_range(0, 3);
      wb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : l;
      for (int i = 0; i <= l; i++) begin wd_a[i] = {$urandom, $urandom}; ws_a[i] = 8'($urandom); end
      axi_write(a, l, 3'd3, wb, $urandom_range(0, 2), 9'($urandom));
      a = 32'($urandom_range(0, 19)) << 3;
      axi_read(a, $urandom_range(0, 3), 3'd3, $urandom_range(0, 2), 9'($urandom));
    end

    // Reset in the middle of a four-beat read.
    @(negedge clk);
    bus.s_arvalid = 1'b1; bus.s_arid = 9'h077; bus.s_araddr = 32'h0; bus.s_arlen = 8'd3;
    bus.s_arsize = 3'd3;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_beat2", bus.s_rdata, ref_mem[2]);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rvalid", 64'(bus.s_rvalid), 64'(0));
    check("mid_rst_arready", 64'(bus.s_arready), 64'(0));
    rst = 1'b0;
    bus.s_rready = 1'b0;
    for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
    @(negedge clk);
    check("mid_rst_rvalid_after", 64'(bus.s_rvalid), 64'(0));
    axi_read(32'h0, NREG - 1, 3'd3, 0, 9'h078);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_mmio_csr_responder.md
# axi_mmio_csr_responder

AXI4 memory-mapped responder that terminates MMIO traffic arriving from a master (for example, the output of an AXI MMIO pipeline register) into a local bank of CSR words. It accepts write-address and write-data bursts and answers them on B. It accepts read-address bursts and streams the data on R. It is the subordinate end of the same AW/W/B/AR/R channel set that the pipeline registers carry, with independent read and write engines.

## Interface
Parameters:
- ID_WIDTH, 9: width of awid/bid/arid/rid.
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 64: data width; must be a power of two, 32 or more.
- NUM_REGS, 16: number of DATA_WIDTH-bit CSR words; power of two, 2 or more.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_awvalid/s_awready  in/out  1  write-address handshake.
- s_awid  in  ID_WIDTH  write transaction ID.
- s_awaddr  in  ADDR_WIDTH  first-beat byte address.
- s_awlen  in  8  beats minus 1.
- s_awsize  in  3  beat size.
- s_wvalid/s_wready  in/out  1  write-data handshake.
- s_wdata  in  DATA_WIDTH  write data.
- s_wstrb  in  DATA_WIDTH/8  byte enables.
- s_wlast  in  1  last beat marker.
- s_bvalid/s_bready  out/in  1  write-response handshake.
- s_bid  out  ID_WIDTH  echoed awid.
- s_bresp  out  2  write response code.
- s_arvalid/s_arready  in/out  1  read-address handshake.
- s_arid  in  ID_WIDTH  read transaction ID.
- s_araddr  in  ADDR_WIDTH  first-beat byte address.
- s_arlen  in  8  beats minus 1.
- s_arsize  in  3  beat size.
- s_rvalid/s_rready  out/in  1  read-data handshake.
- s_rid  out  ID_WIDTH  echoed arid.
- s_rdata  out  DATA_WIDTH  read data.
- s_rresp  out  2  read response code.
- s_rlast  out  1  last read beat.

## Operation
- Word index is the byte address shifted right by log2(DATA_WIDTH/8). The index is in range when it is less than NUM_REGS. Each beat advances the index by 1, so every burst is treated as INCR and awburst/arburst are not used.
- Write FSM has three states.
  - W_IDLE: s_awready=1. On the AW handshake, latch id, index and len, clear the error flags, and go to W_DATA.
  - W_DATA: s_wready=1. On each W handshake:
    - If the beat's index is in range, write the bytes whose wstrb bit is 1.
    - If the index is out of range, skip the write and set the decode-error flag.
    - If wlast does not match the last-beat position (count == len), set the protocol-error flag.
    - The burst ends at count == len, regardless of wlast. The FSM then goes to W_RESP.
  - W_RESP: s_bvalid=1. s_bresp is 2'b11 (DECERR) if the decode-error flag is set, otherwise 2'b10 (SLVERR) if the protocol-error flag is set, otherwise 2'b00. The FSM returns to W_IDLE on s_bready.
- Read FSM has two states.
  - R_IDLE: s_arready=1. On the AR handshake, load the rdata register with the word at the first index and go to R_DATA.
  - R_DATA: s_rvalid=1 and rid=arid. s_rresp is 2'b00 when the beat's index is in range, else 2'b11 with rdata=0. s_rlast=1 when count == len.
    - A handshake with rlast=0 loads the next beat.
    - A handshake with rlast=1 returns to R_IDLE.
- Read and write engines run concurrently. If a read sample and a write commit hit the same word in the same cycle, the read returns the pre-write value.
- Reset: all CSR words are 0, both FSMs go idle, and all outputs are 0, including the readies. s_awready and s_arready rise in the first cycle after rst falls. A reset in the middle of a burst aborts it; no B or R is issued for it.

## Timing
- Write: the earliest W beat is accepted 1 cycle after the AW handshake. s_bvalid rises 1 cycle after the final W handshake. Beats are back-to-back at 1 per cycle.
- Read: s_rvalid rises 1 cycle after the AR handshake. Beats are 1 per cycle while s_rready=1.
- Outputs hold stable while valid=1 and ready=0. The next AW is accepted the cycle after the B handshake; the next AR is accepted the cycle after the rlast handshake.
- s_awready and s_arready do not combinationally depend on the valids.

## Configuration
- Macro: AXI_MMIO_CSR_RESPONDER_SIZE_CHECK_EN.
- Defined:
  - An AW whose awsize is not log2(DATA_WIDTH/8), or whose awaddr low bits are non-zero, still consumes all its beats. No CSR is written, and the response is SLVERR (2'b10).
  - The matching AR case returns SLVERR with rdata=0 on every beat.
- Undefined: awsize and arsize are ignored, and the low address bits are truncated.

## Test plan
- Write 0x0000_0000_DEAD_BEEF to 0x08 with len=0 and wstrb=0xFF -> bresp=0. A read of 0x08 returns the same data with rresp=0 and rlast=1, and rvalid rises 1 cycle after the AR handshake.
- Write burst to 0x10 with len=3 and data 1,2,3,4 (wstrb=0x0F on beat 2) -> words 2..5 hold 1, 2, 3 and 4 respectively, with beat 2's upper bytes preserved. A read burst with len=3 returns them with rlast only on beat 3.
- Read burst at 0x78 with len=1 (NUM_REGS=16) -> beat 0 returns word 15 with OKAY; beat 1 returns rdata=0, rresp=2'b11 and rlast=1.
- Write with len=1 and wlast=1 on beat 0 -> bresp=2'b10, both beats are written, and one B is issued.
- s_rready and s_bready held at 0 for 5 cycles -> rvalid, rdata, bvalid and bresp stay stable; with the macro defined, awsize=2 gives bresp=2'b10 and no CSR change.
- Assert rst during beat 2 of a 4-beat read -> rvalid=0 in the next cycle, and all CSRs read back 0 afterwards.
